// File: rtl/apb_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_cmd_master: FIFO-buffered command queue driving an APB master with     |
// | odd byte parity, read parity checking and an ACCESS-phase timeout.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module apb_cmd_master #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255,
  localparam int NB     = DATA_W / 8,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              apbclk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [NB-1:0]     cmd_strb,
  output logic [LVL_W-1:0]  cmd_level,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              rsp_parerr,
  output logic              busy,
  output logic [ADDR_W-1:0] APB_PADDR,
  output logic              APB_PSEL,
  output logic              APB_PENABLE,
  output logic              APB_PWRITE,
  output logic [DATA_W-1:0] APB_PWDATA,
  output logic [NB-1:0]     APB_PWDATA_PAR,
  output logic [NB-1:0]     APB_PSTRB,
  output logic              APB_PSTRB_PAR,
  input  logic [DATA_W-1:0] APB_PRDATA,
  input  logic [NB-1:0]     APB_PRDATA_PAR,
  input  logic              APB_PREADY,
  input  logic              APB_PSLVERR
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_EW = 1 + ADDR_W + DATA_W + NB;
  localparam int c_TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit c_TO_EN = (TIMEOUT > 0);
  localparam logic [c_TW:0] c_TO = TIMEOUT[c_TW:0];
  localparam logic [LVL_W-1:0] c_FULL = DEPTH[LVL_W-1:0];

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SETUP  = 2'd1;
  localparam logic [1:0] c_ACCESS = 2'd2;
  localparam logic [1:0] c_RESP   = 2'd3;

  logic [1:0]        r_state, w_state_nxt;
  logic              r_psel, r_penable, r_rsp_valid;
  logic              w_psel_nxt, w_penable_nxt, w_rsp_valid_nxt;
  logic [c_EW-1:0]   r_mem [DEPTH];
  logic [c_PW-1:0]   r_wptr, r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_push, w_pop;
  logic [c_EW-1:0]   w_head;
  logic              w_h_write;
  logic [ADDR_W-1:0] w_h_addr;
  logic [DATA_W-1:0] w_h_wdata;
  logic [NB-1:0]     w_h_strb;
  logic [c_TW-1:0]   r_tcnt;
  logic [c_TW:0]     w_tcnt_inc;
  logic              w_timeout;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic [NB-1:0]     r_pstrb;
  logic [NB-1:0]     w_rpar;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err, r_rsp_timeout, r_rsp_parerr;

  assign cmd_ready = (r_level != c_FULL);
  assign cmd_level = r_level;
  assign w_push    = cmd_valid & cmd_ready;
  assign w_pop     = (r_state == c_IDLE) && (r_level != '0);

  assign w_head    = r_mem[r_rptr];
  assign w_h_write = w_head[c_EW-1];
  assign w_h_addr  = w_head[NB+DATA_W +: ADDR_W];
  assign w_h_wdata = w_head[NB +: DATA_W];
  assign w_h_strb  = w_head[NB-1:0];

  always_ff @(posedge apbclk) begin
    if (w_push) r_mem[r_wptr] <= {cmd_write, cmd_addr, cmd_wdata, cmd_strb};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge apbclk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PW'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign w_tcnt_inc = {1'b0, r_tcnt} + (c_TW+1)'(1);
  assign w_timeout  = c_TO_EN && (w_tcnt_inc == c_TO);

  always_ff @(posedge apbclk or negedge rstn) begin
    if (!rstn) begin
      r_tcnt <= '0;
    end else if (r_state == c_SETUP) begin
      r_tcnt <= '0;
    end else if (r_state == c_ACCESS && !APB_PREADY) begin
      r_tcnt <= w_tcnt_inc[c_TW-1:0];
    end
  end

  // State register; APB strobes and rsp_valid are registered from the next state.
  always_ff @(posedge apbclk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= c_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   if (r_level != '0) w_state_nxt = c_SETUP;
      c_SETUP:  w_state_nxt = c_ACCESS;
      c_ACCESS: if (APB_PREADY || w_timeout) w_state_nxt = c_RESP;
      c_RESP:   if (rsp_ready) w_state_nxt = c_IDLE;
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_psel_nxt      = (w_state_nxt == c_SETUP) || (w_state_nxt == c_ACCESS);
    w_penable_nxt   = (w_state_nxt == c_ACCESS);
    w_rsp_valid_nxt = (w_state_nxt == c_RESP);
  end

  for (genvar i = 0; i < NB; i++) begin : g_par
    assign APB_PWDATA_PAR[i] = ~^r_pwdata[8*i +: 8];
    assign w_rpar[i]         = ~^APB_PRDATA[8*i +: 8];
  end

  always_ff @(posedge apbclk or negedge rstn) begin
    if (!rstn) begin
      r_paddr       <= '0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_parerr  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_paddr  <= w_h_addr;
        r_pwrite <= w_h_write;
        r_pwdata <= w_h_wdata;
        r_pstrb  <= w_h_write ? w_h_strb : '0;
      end else if (w_state_nxt == c_IDLE || w_state_nxt == c_RESP) begin
        r_pwrite <= 1'b0;
        r_pwdata <= '0;
        r_pstrb  <= '0;
      end
      // PREADY wins over a timeout landing on the same edge.
      if (r_state == c_ACCESS && APB_PREADY) begin
        r_rsp_rdata   <= r_pwrite ? '0 : APB_PRDATA;
        r_rsp_err     <= APB_PSLVERR;
        r_rsp_timeout <= 1'b0;
        r_rsp_parerr  <= !r_pwrite && (APB_PRDATA_PAR != w_rpar);
      end else if (r_state == c_ACCESS && w_timeout) begin
        r_rsp_rdata   <= '0;
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= 1'b1;
        r_rsp_parerr  <= 1'b0;
      end else if (r_state == c_RESP && rsp_ready) begin
        r_rsp_rdata   <= '0;
        r_rsp_err     <= 1'b0;
        r_rsp_timeout <= 1'b0;
        r_rsp_parerr  <= 1'b0;
      end
    end
  end

  assign APB_PSEL      = r_psel;
  assign APB_PENABLE   = r_penable;
  assign APB_PADDR     = r_paddr;
  assign APB_PWRITE    = r_pwrite;
  assign APB_PWDATA    = r_pwdata;
  assign APB_PSTRB     = r_pstrb;
  assign APB_PSTRB_PAR = ~^r_pstrb;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_err       = r_rsp_err;
  assign rsp_timeout   = r_rsp_timeout;
  assign rsp_parerr    = r_rsp_parerr;
  assign busy          = (r_state != c_IDLE) || (r_level != '0);

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_apb_cmd_master: randomized bench with a transaction-level APB model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_apb_cmd_master;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int TO     = 8;
  localparam int NB     = 4;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [NB-1:0]     strb;
  } cmd_t;

  logic              apbclk, rstn;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [NB-1:0]     cmd_strb;
  logic [2:0]        cmd_level;
  logic              rsp_valid, rsp_ready, rsp_err, rsp_timeout, rsp_parerr, busy;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] APB_PADDR;
  logic              APB_PSEL, APB_PENABLE, APB_PWRITE, APB_PSTRB_PAR;
  logic [DATA_W-1:0] APB_PWDATA, APB_PRDATA;
  logic [NB-1:0]     APB_PWDATA_PAR, APB_PSTRB, APB_PRDATA_PAR;
  logic              APB_PREADY, APB_PSLVERR;

  cmd_t model_q[$];
  int   total = 0;
  int   bad   = 0;

  apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .apbclk(apbclk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_level(cmd_level),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .rsp_parerr(rsp_parerr), .busy(busy),
    .APB_PADDR(APB_PADDR), .APB_PSEL(APB_PSEL), .APB_PENABLE(APB_PENABLE),
    .APB_PWRITE(APB_PWRITE), .APB_PWDATA(APB_PWDATA), .APB_PWDATA_PAR(APB_PWDATA_PAR),
    .APB_PSTRB(APB_PSTRB), .APB_PSTRB_PAR(APB_PSTRB_PAR), .APB_PRDATA(APB_PRDATA),
    .APB_PRDATA_PAR(APB_PRDATA_PAR), .APB_PREADY(APB_PREADY), .APB_PSLVERR(APB_PSLVERR)
  );

  initial apbclk = 1'b0;
  always #5 apbclk = ~apbclk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [NB-1:0] opar(input logic [DATA_W-1:0] d);
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) p[i] = ~^d[8*i +: 8];
    return p;
  endfunction

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    logic [31:0] r;
    r = $urandom;
    c.write = r[31];
    c.addr  = r[ADDR_W-1:0];
    c.wdata = $urandom;
    r = $urandom;
    c.strb  = r[NB-1:0];
    return c;
  endfunction

  // Offer one command and wait until the FIFO takes it.
  task automatic push(input cmd_t c);
    int n;
    cmd_valid = 1'b1;
    cmd_write = c.write;
    cmd_addr  = c.addr;
    cmd_wdata = c.wdata;
    cmd_strb  = c.strb;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 300) begin
      @(negedge apbclk);
      n++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL push_accept cmd_ready=%b want 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    model_q.push_back(c);
    @(negedge apbclk);
    cmd_valid = 1'b0;
  endtask

  // Acts as the APB slave for one transfer: PREADY in ACCESS cycle index w.
  task automatic serve(input int w, input logic [DATA_W-1:0] prdata, input logic [NB-1:0] flip,
                       input logic slverr, input int hold, output int waited);
    cmd_t              c;
    int                n, xcyc;
    logic [NB-1:0]     xstrb;
    logic [DATA_W-1:0] xrd;
    logic              xerr, xto, xpe;
    n = 0;
    while (APB_PSEL !== 1'b1 && n < 40) begin
      @(negedge apbclk);
      n++;
    end
    waited = n;
    total++;
    if (APB_PSEL !== 1'b1) begin
      bad++;
      $display("FAIL serve_start psel=%b want 1", APB_PSEL);
      return;
    end
    total++;
    if (model_q.size() == 0) begin
      bad++;
      $display("FAIL serve_order psel=%b but no command pending", APB_PSEL);
      return;
    end
    c = model_q.pop_front();
    xstrb = c.write ? c.strb : '0;
    total++;
    if (APB_PENABLE !== 1'b0 || APB_PADDR !== c.addr || APB_PWRITE !== c.write ||
        APB_PSTRB !== xstrb || APB_PSTRB_PAR !== ~^xstrb ||
        (c.write && (APB_PWDATA !== c.wdata || APB_PWDATA_PAR !== opar(c.wdata)))) begin
      bad++;
      $display("FAIL setup got en=%b addr=%h wr=%b strb=%h spar=%b wd=%h wpar=%h want addr=%h wr=%b strb=%h wd=%h wpar=%h",
               APB_PENABLE, APB_PADDR, APB_PWRITE, APB_PSTRB, APB_PSTRB_PAR, APB_PWDATA,
               APB_PWDATA_PAR, c.addr, c.write, xstrb, c.wdata, opar(c.wdata));
    end
    @(negedge apbclk);
    n = 0;
    while (n < 40) begin
      total++;
      if (APB_PSEL !== 1'b1 || APB_PENABLE !== 1'b1 || busy !== 1'b1 || APB_PADDR !== c.addr ||
          APB_PWRITE !== c.write || APB_PSTRB !== xstrb || (c.write && APB_PWDATA !== c.wdata)) begin
        bad++;
        $display("FAIL access_hold cyc=%0d got sel=%b en=%b busy=%b addr=%h wr=%b strb=%h want 1 1 1 %h %b %h",
                 n, APB_PSEL, APB_PENABLE, busy, APB_PADDR, APB_PWRITE, APB_PSTRB, c.addr, c.write, xstrb);
      end
      if (n == w) begin
        APB_PREADY     = 1'b1;
        APB_PRDATA     = prdata;
        APB_PRDATA_PAR = opar(prdata) ^ flip;
        APB_PSLVERR    = slverr;
      end
      @(negedge apbclk);
      APB_PREADY  = 1'b0;
      APB_PSLVERR = 1'b0;
      n++;
      if (APB_PSEL !== 1'b1) break;
    end
    xcyc = (w < TO) ? w + 1 : TO;
    total++;
    if (n != xcyc || APB_PENABLE !== 1'b0) begin
      bad++;
      $display("FAIL access_len got=%0d en=%b want=%0d en=0", n, APB_PENABLE, xcyc);
    end
    if (w >= TO) begin
      xrd = '0; xerr = 1'b1; xto = 1'b1; xpe = 1'b0;
    end else begin
      xrd  = c.write ? '0 : prdata;
      xerr = slverr;
      xto  = 1'b0;
      xpe  = !c.write && (flip != '0);
    end
    for (int h = 0; h <= hold; h++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== xrd || rsp_err !== xerr || rsp_timeout !== xto ||
          rsp_parerr !== xpe || APB_PSEL !== 1'b0 || APB_PWRITE !== 1'b0 || APB_PSTRB !== '0 ||
          APB_PWDATA !== '0 || APB_PADDR !== c.addr) begin
        bad++;
        $display("FAIL rsp got v=%b rd=%h err=%b to=%b pe=%b sel=%b wr=%b addr=%h want v=1 rd=%h err=%b to=%b pe=%b sel=0 wr=0 addr=%h",
                 rsp_valid, rsp_rdata, rsp_err, rsp_timeout, rsp_parerr, APB_PSEL, APB_PWRITE,
                 APB_PADDR, xrd, xerr, xto, xpe, c.addr);
      end
      if (h == hold) rsp_ready = 1'b1;
      @(negedge apbclk);
    end
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rsp_release rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #12;
    total++;
    if ({APB_PSEL, APB_PENABLE, APB_PWRITE} !== 3'b000 || APB_PADDR !== '0 ||
        APB_PWDATA !== '0 || APB_PSTRB !== '0) begin
      bad++;
      $display("FAIL reset_apb sel=%b en=%b wr=%b addr=%h wd=%h strb=%h want all 0",
               APB_PSEL, APB_PENABLE, APB_PWRITE, APB_PADDR, APB_PWDATA, APB_PSTRB);
    end
    total++;
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_parerr} !== 4'b0000 || rsp_rdata !== '0) begin
      bad++;
      $display("FAIL reset_rsp v=%b err=%b to=%b pe=%b rd=%h want all 0",
               rsp_valid, rsp_err, rsp_timeout, rsp_parerr, rsp_rdata);
    end
    total++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || cmd_level !== 3'd0) begin
      bad++;
      $display("FAIL reset_fifo busy=%b ready=%b level=%0d want 0 1 0", busy, cmd_ready, cmd_level);
    end
    @(negedge apbclk);
    rstn = 1'b1;
    repeat (4) begin
      @(negedge apbclk);
      total++;
      if (APB_PSEL !== 1'b0 || APB_PENABLE !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_empty sel=%b en=%b busy=%b want 0 0 0", APB_PSEL, APB_PENABLE, busy);
      end
    end
  endtask

  task automatic test_write();
    cmd_t c;
    int   wt;
    c.write = 1'b1;
    c.addr  = 24'h000010;
    c.wdata = 32'hA5A5_0F0F;
    c.strb  = 4'hF;
    push(c);
    total++;
    if (APB_PSEL !== 1'b0) begin
      bad++;
      $display("FAIL latency_early psel=%b want 0", APB_PSEL);
    end
    serve(0, $urandom, '0, 1'b0, 0, wt);
    total++;
    if (wt != 1) begin
      bad++;
      $display("FAIL latency cycles_to_psel=%0d want 1", wt);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL write_done busy=%b want 0", busy);
    end
  endtask

  task automatic test_read();
    cmd_t c;
    int   wt;
    c = rnd_cmd();
    c.write = 1'b0;
    c.strb  = 4'hF;
    push(c);
    serve(3, 32'h1234_5678, 4'h0, 1'b0, 2, wt);
    c = rnd_cmd();
    c.write = 1'b0;
    push(c);
    serve(3, 32'h1234_5678, 4'h1, 1'b0, 0, wt);
    c = rnd_cmd();
    c.write = 1'b0;
    push(c);
    serve(1, $urandom, 4'h0, 1'b1, 1, wt);
  endtask

  task automatic test_timeout();
    cmd_t c;
    int   wt;
    c = rnd_cmd();
    c.write = 1'b0;
    push(c);
    serve(200, $urandom, 4'h0, 1'b0, 1, wt);
    c = rnd_cmd();
    push(c);
    serve(TO - 1, $urandom, 4'h0, 1'b0, 0, wt);
    c = rnd_cmd();
    c.write = 1'b1;
    push(c);
    serve(TO, $urandom, 4'h0, 1'b1, 0, wt);
  endtask

  task automatic test_fifo_full();
    rsp_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) push(rnd_cmd());
      end
      begin
        int wt;
        serve(0, $urandom, '0, 1'b0, 10, wt);
        for (int i = 0; i < 5; i++) serve($urandom_range(0, 2), $urandom, '0, 1'b0, 0, wt);
      end
      begin
        repeat (7) @(negedge apbclk);
        total++;
        if (cmd_level !== 3'd4 || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
          bad++;
          $display("FAIL fifo_full level=%0d ready=%b rsp_valid=%b want 4 0 1", cmd_level, cmd_ready, rsp_valid);
        end
        push(rnd_cmd());
      end
    join
    total++;
    if (cmd_level !== 3'd0 || busy !== 1'b0 || model_q.size() != 0) begin
      bad++;
      $display("FAIL fifo_drain level=%0d busy=%b pending=%0d want 0 0 0", cmd_level, busy, model_q.size());
    end
  endtask

  task automatic test_random();
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          push(rnd_cmd());
          repeat ($urandom_range(0, 2)) @(negedge apbclk);
        end
      end
      begin
        int wt;
        for (int i = 0; i < 16; i++) begin
          int               w;
          logic [NB-1:0]    flip;
          logic [31:0]      r;
          r = $urandom;
          w = (r[2:0] == 3'd0) ? TO + 2 : $urandom_range(0, 3);
          flip = (r[4:3] == 2'd0) ? NB'(1) << r[6:5] : '0;
          serve(w, $urandom, flip, (r[8:7] == 2'd0), $urandom_range(0, 2), wt);
        end
      end
    join
  endtask

  task automatic test_reset_access();
    logic ok;
    push(rnd_cmd());
    push(rnd_cmd());
    total++;
    if (APB_PSEL !== 1'b1 || APB_PENABLE !== 1'b0) begin
      bad++;
      $display("FAIL rst_pre_setup sel=%b en=%b want 1 0", APB_PSEL, APB_PENABLE);
    end
    @(negedge apbclk);
    total++;
    if (APB_PENABLE !== 1'b1 || cmd_level !== 3'd1) begin
      bad++;
      $display("FAIL rst_pre_access en=%b level=%0d want 1 1", APB_PENABLE, cmd_level);
    end
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if (APB_PSEL !== 1'b0 || APB_PENABLE !== 1'b0 || cmd_level !== 3'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_async sel=%b en=%b level=%0d busy=%b ready=%b want 0 0 0 0 1",
               APB_PSEL, APB_PENABLE, cmd_level, busy, cmd_ready);
    end
    model_q.delete();
    @(negedge apbclk);
    rstn = 1'b1;
    ok = 1'b1;
    repeat (6) begin
      @(negedge apbclk);
      if (rsp_valid !== 1'b0 || APB_PSEL !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rst_after rsp_valid=%b sel=%b want 0 0 throughout", rsp_valid, APB_PSEL);
    end
  endtask

  initial begin
    rstn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    rsp_ready = 1'b0;
    APB_PRDATA = '0; APB_PRDATA_PAR = '0; APB_PREADY = 1'b0; APB_PSLVERR = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_fifo_full();
    test_random();
    test_reset_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
